// File: rtl/bcd_multi_counter_pkg.sv
// bcd_multi_counter_pkg: shared BCD digit type, digit limits and load sanitizer
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction
endpackage

// File: rtl/bcd_multi_counter_if.sv
// bcd_multi_counter_if: control/data bundle of the counter; up_down exists only with BCD_COUNTER_DOWN_EN
interface bcd_multi_counter_if #(parameter int DIGITS = 2);
    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
`ifdef BCD_COUNTER_DOWN_EN
    logic                  up_down;
`endif
    logic [4*DIGITS-1:0]   bcd;
    logic                  carry_out;
    logic                  invalid;
    modport master (
`ifdef BCD_COUNTER_DOWN_EN
        output up_down,
`endif
        output enable, clear, load, load_value,
        input  bcd, carry_out, invalid
    );
    modport slave (
`ifdef BCD_COUNTER_DOWN_EN
        input  up_down,
`endif
        input  enable, clear, load, load_value,
        output bcd, carry_out, invalid
    );
endinterface

// File: rtl/bcd_multi_counter_digit.sv
// bcd_digit: one BCD digit register with clear, sanitizing load and up/down step
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       step,
    input  logic       dir,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_min
);
    bcd_digit_t up, dn;
    assign up     = (q >= BCD_MAX) ? BCD_MIN : bcd_digit_t'(q + 4'd1);
    assign dn     = (q == BCD_MIN) ? BCD_MAX : (q > BCD_MAX) ? BCD_MIN : bcd_digit_t'(q - 4'd1);
    assign at_max = q == BCD_MAX;
    assign at_min = q == BCD_MIN;
    // digit register: clear beats load beats step; an out-of-range digit steps to 0
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) q <= BCD_MIN;
        else q <= clr ? BCD_MIN : ld ? bcd_sanitize(ld_val) : step ? (dir ? up : dn) : q;
endmodule

// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: cascaded DIGITS-digit BCD counter with wrap/saturate; BCD_COUNTER_DOWN_EN adds down counting
module bcd_multi_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    bcd_multi_counter_if.slave bus
);
    logic [DIGITS-1:0]   at_max, at_min, step, bad;
    logic [DIGITS:0]     chain;
    logic [4*DIGITS-1:0] q;
    logic                dir, full, ovf, carry_q, invalid_q;
`ifdef BCD_COUNTER_DOWN_EN
    assign dir = bus.up_down;
`else
    assign dir = 1'b1;
`endif
    assign full     = dir ? &at_max : &at_min;
    assign ovf      = bus.enable && full;
    assign chain[0] = 1'b1;
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            assign chain[g+1] = chain[g] && (dir ? at_max[g] : at_min[g]);
            assign step[g]    = bus.enable && chain[g] && (WRAP || !full);
            assign bad[g]     = bus.load_value[4*g+:4] > BCD_MAX;
            bcd_digit u_digit (
                .clock  (clock),
                .reset_n(reset_n),
                .step   (step[g]),
                .dir    (dir),
                .clr    (bus.clear),
                .ld     (bus.load),
                .ld_val (bus.load_value[4*g+:4]),
                .q      (q[4*g+:4]),
                .at_max (at_max[g]),
                .at_min (at_min[g])
            );
        end
    endgenerate
    // event flags pulse for one cycle alongside the bcd value they describe
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            carry_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            carry_q   <= !bus.clear && !bus.load && ovf;
            invalid_q <= !bus.clear && bus.load && |bad;
        end
    assign bus.bcd       = q;
    assign bus.carry_out = carry_q;
    assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter: directed checks of wrap and saturate counters (plus down counting with BCD_COUNTER_DOWN_EN)
module tb_bcd_multi_counter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clock = ~clock;
    bcd_multi_counter_if #(.DIGITS(2)) if_w ();
    bcd_multi_counter_if #(.DIGITS(2)) if_s ();
    bcd_multi_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (.clock(clock), .reset_n(reset_n), .bus(if_w));
    bcd_multi_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat  (.clock(clock), .reset_n(reset_n), .bus(if_s));
`ifdef BCD_COUNTER_DOWN_EN
    logic ud;
    bcd_multi_counter_if #(.DIGITS(3)) if_3 ();
    bcd_multi_counter #(.DIGITS(3), .WRAP(1'b1)) u_d3 (.clock(clock), .reset_n(reset_n), .bus(if_3));
    assign if_w.up_down = ud;
    assign if_s.up_down = ud;
    assign if_3.up_down = ud;
`endif
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input logic en, input logic clr, input logic ld, input logic [11:0] val);
        if_w.enable = en; if_w.clear = clr; if_w.load = ld; if_w.load_value = val[7:0];
        if_s.enable = en; if_s.clear = clr; if_s.load = ld; if_s.load_value = val[7:0];
`ifdef BCD_COUNTER_DOWN_EN
        if_3.enable = en; if_3.clear = clr; if_3.load = ld; if_3.load_value = val;
`endif
        @(posedge clock);
        #1;
    endtask
    initial begin
        logic [7:0] e;
        int c;
`ifdef BCD_COUNTER_DOWN_EN
        ud = 1'b1;
`endif
        if_w.enable = 0; if_w.clear = 0; if_w.load = 0; if_w.load_value = '0;
        if_s.enable = 0; if_s.clear = 0; if_s.load = 0; if_s.load_value = '0;
        #12;
        chk("rst_bcd", if_w.bcd, 8'h00);
        chk("rst_carry", if_w.carry_out, 1'b0);
        chk("rst_invalid", if_w.invalid, 1'b0);
        reset_n = 1'b1;
        repeat (37) cyc(1, 0, 0, 0);
        chk("count37_w", if_w.bcd, 8'h37);
        chk("count37_s", if_s.bcd, 8'h37);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_bcd", if_w.bcd, 8'h00);
        chk("async_rst_carry", if_w.carry_out, 1'b0);
        #2 reset_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cyc(1, 0, 0, 0);
            c = i % 100;
            e = {4'(c / 10), 4'(c % 10)};
            chk("sweep_bcd", if_w.bcd, e);
            chk("sweep_carry", if_w.carry_out, c == 0);
        end
        chk("sweep_sat_bcd", if_s.bcd, 8'h99);
        chk("sweep_sat_carry", if_s.carry_out, 1'b1);
        cyc(0, 0, 1, 12'h047);
        chk("load47", if_w.bcd, 8'h47);
        chk("load47_inv", if_w.invalid, 1'b0);
        cyc(1, 0, 0, 0);
        chk("casc48", if_w.bcd, 8'h48);
        cyc(1, 0, 0, 0);
        chk("casc49", if_w.bcd, 8'h49);
        cyc(1, 0, 0, 0);
        chk("casc50", if_w.bcd, 8'h50);
        chk("casc50_carry", if_w.carry_out, 1'b0);
        cyc(0, 0, 1, 12'h0A5);
        chk("loadA5", if_w.bcd, 8'h05);
        chk("loadA5_inv", if_w.invalid, 1'b1);
        cyc(0, 0, 0, 0);
        chk("hold05", if_w.bcd, 8'h05);
        chk("inv_drop", if_w.invalid, 1'b0);
        cyc(0, 0, 1, 12'h0FF);
        chk("loadFF", if_w.bcd, 8'h00);
        chk("loadFF_inv", if_w.invalid, 1'b1);
        cyc(1, 1, 1, 12'h012);
        chk("prio_clear", if_w.bcd, 8'h00);
        chk("prio_clear_inv", if_w.invalid, 1'b0);
        cyc(1, 0, 1, 12'h012);
        chk("prio_load", if_w.bcd, 8'h12);
        cyc(0, 0, 1, 12'h099);
        cyc(1, 1, 0, 0);
        chk("clr_full_bcd", if_s.bcd, 8'h00);
        chk("clr_full_carry", if_s.carry_out, 1'b0);
        cyc(0, 0, 1, 12'h098);
        cyc(1, 0, 0, 0);
        chk("sat1_bcd", if_s.bcd, 8'h99);
        chk("sat1_carry", if_s.carry_out, 1'b0);
        chk("wrap1_bcd", if_w.bcd, 8'h99);
        cyc(1, 0, 0, 0);
        chk("sat2_bcd", if_s.bcd, 8'h99);
        chk("sat2_carry", if_s.carry_out, 1'b1);
        chk("wrap2_bcd", if_w.bcd, 8'h00);
        chk("wrap2_carry", if_w.carry_out, 1'b1);
        cyc(1, 0, 0, 0);
        chk("sat3_bcd", if_s.bcd, 8'h99);
        chk("sat3_carry", if_s.carry_out, 1'b1);
        chk("wrap3_bcd", if_w.bcd, 8'h01);
        chk("wrap3_carry", if_w.carry_out, 1'b0);
        cyc(0, 0, 0, 0);
        chk("sat_hold_bcd", if_s.bcd, 8'h99);
        chk("sat_hold_carry", if_s.carry_out, 1'b0);
`ifdef BCD_COUNTER_DOWN_EN
        cyc(0, 0, 1, 12'h001);
        ud = 1'b0;
        cyc(1, 0, 0, 0);
        chk("down00_w", if_w.bcd, 8'h00);
        chk("down00_carry", if_w.carry_out, 1'b0);
        cyc(1, 0, 0, 0);
        chk("down99_w", if_w.bcd, 8'h99);
        chk("down99_carry", if_w.carry_out, 1'b1);
        chk("down_sat_bcd", if_s.bcd, 8'h00);
        chk("down_sat_carry", if_s.carry_out, 1'b1);
        cyc(0, 0, 1, 12'h100);
        cyc(1, 0, 0, 0);
        chk("down_d3", if_3.bcd, 12'h099);
        chk("down_d3_carry", if_3.carry_out, 1'b0);
        ud = 1'b1;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
